imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Controller for the single-port synchronous instruction memory. It shares the port between the core's fetch stage (reads) and the boot/debug program loader (writes). It holds the core in a load phase until the loader signals completion, and detects misaligned fetch PCs. It sits between the fetch stage, the loader, and the instruction RAM macro.

## Interface
- `PC_WIDTH`, 32, width of fetch PC and loader byte address
- `INST_WIDTH`, 32, instruction/data word width
- `ADDR_WIDTH`, 9, memory word-address width (depth 1<<9)
- `STARVE_MAX`, 4, consecutive cycles a loader request may wait in RUN before it is forced a slot
- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `fetch_req` in 1: fetch read request
- `fetch_pc` in PC_WIDTH: byte address of the fetch
- `fetch_gnt` out 1: fetch request accepted this cycle
- `fetch_valid` out 1: `fetch_inst` valid (one cycle after the grant)
- `fetch_inst` out INST_WIDTH: returned instruction
- `fetch_misalign` out 1: qualifies `fetch_valid`; the granted PC had `[1:0]` != 0
- `ld_req` in 1: loader write request
- `ld_addr` in PC_WIDTH: loader byte address
- `ld_data` in INST_WIDTH: loader write word
- `ld_gnt` out 1: write accepted this cycle
- `ld_done` in 1: loader finished; level or pulse
- `cpu_run` out 1: core released to execute
- `mem_en` out 1: memory port enable
- `mem_we` out 1: memory write enable
- `mem_addr` out ADDR_WIDTH: memory word address
- `mem_wdata` out INST_WIDTH: memory write data
- `mem_rdata` in INST_WIDTH: memory read data, valid the cycle after `mem_en && !mem_we`

## Operation
- FSM states: LOAD (reset state) and RUN.
- **LOAD**
  - Only the loader is served: `ld_gnt = ld_req`. `fetch_gnt` is 0 and `cpu_run` is 0.
  - `ld_done` sampled high moves the FSM to RUN next cycle. A write granted in that same cycle still completes.
- **RUN**
  - `cpu_run` is 1. Fetch has priority.
  - A loader request is granted when `fetch_req` is 0, or when the starvation counter reaches `STARVE_MAX`.
  - The starvation counter increments each cycle `ld_req` is high and not granted. It clears on `ld_gnt` or when `ld_req` is low.
  - When the loader is forced a slot, `fetch_gnt` is 0 that cycle. RUN is left only by `rst`.
- **Memory mapping**
  - `mem_addr = addr[ADDR_WIDTH+1:2]`. Upper address bits are ignored, so addresses wrap modulo the memory depth.
  - Loader writes ignore `ld_addr[1:0]`.
- **Misaligned fetch**
  - A granted fetch with `fetch_pc[1:0]` != 0 does not enable memory (`mem_en` = 0).
  - Next cycle: `fetch_valid` = 1, `fetch_misalign` = 1, `fetch_inst` = 32'h00000013 (NOP).
- **Aligned fetch**
  - `fetch_inst = mem_rdata` and `fetch_misalign` = 0.
- At most one grant per cycle. `mem_en` is high exactly when an aligned fetch or a loader write is granted.

## Timing
- Grants are combinational from the requests and the registered FSM/counter state.
- `mem_*` outputs are combinational with the grant.
- Read latency: `fetch_valid` is exactly 1 cycle after `fetch_gnt`. Back-to-back fetches give one instruction per cycle.
- `fetch_inst` is held when `fetch_valid` is 0.
- Reset values: FSM = LOAD; `cpu_run`, `fetch_valid`, `fetch_misalign` = 0; `fetch_inst` = 0; starvation counter = 0.
- Reset mid-operation: any in-flight read is discarded (`fetch_valid` is 0 the cycle after `rst`) and the FSM returns to LOAD.
- `ld_done` and `ld_req` together in LOAD: the write is granted and the transition happens.
- `fetch_req` in LOAD is ignored; it is not queued.

## Configuration
- `IMEM_ARB_STARVE_EN`
  - Defined: the starvation counter and forced loader slot in RUN are present, as described above.
  - Undefined: no counter. In RUN the loader is granted only when `fetch_req` is 0, and `STARVE_MAX` is unused.

## Structure
- Shared package `imem_pkg`:
  - FSM state typedef (LOAD, RUN)
  - NOP constant 32'h00000013
  - Default width constants
- One sub-module `imem_starve_cnt`: the saturating starvation counter. Instantiated only under `IMEM_ARB_STARVE_EN`.
- Arbitration, FSM and the response register stay in `imem_arbiter`.

## Test plan
- **Reset and load.** After reset, loader writes 0xDEADBEEF at byte address 0x8 → `mem_we`=1, `mem_addr`=2, `cpu_run`=0. `fetch_req` is held high and `fetch_gnt` stays 0.
- **Release and fetch.** `ld_done` pulse, then fetch of PC 0x8 → `cpu_run`=1 the next cycle; `fetch_valid`=1 one cycle after the grant with `fetch_inst`=0xDEADBEEF.
- **Misaligned fetch.** Fetch of PC 0x6 → `mem_en`=0; next cycle `fetch_valid`=1, `fetch_misalign`=1, `fetch_inst`=0x00000013.
- **Starvation.** With the macro defined, continuous `fetch_req` plus `ld_req` in RUN → `ld_gnt` on the 5th cycle (`STARVE_MAX`=4) and `fetch_gnt`=0 that cycle. Without the macro, no `ld_gnt` until `fetch_req` drops.
- **Address wrap.** Fetch of PC 0x800 after writing word 0 → `mem_addr`=0, returns the word-0 data.
- **Reset mid-read.** `rst` asserted in the cycle after `fetch_gnt` → `fetch_valid`=0, FSM in LOAD, `cpu_run`=0.

Source files
------------

// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared types and constants for the instruction-memory arbiter slice.
//   - imem_state_e : arbiter FSM state (LOAD while the program is loaded,
//                    RUN once the core is released)
//   - NOP_INST     : instruction returned for a misaligned fetch
//   - DEF_*        : default widths / starvation limit used by the top
//   - is_misaligned: word-alignment test on the two low PC bits
// -----------------------------------------------------------------------------
package imem_pkg;

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } imem_state_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam int DEF_PC_WIDTH   = 32;
    localparam int DEF_INST_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 9;
    localparam int DEF_STARVE_MAX = 4;

    // A fetch PC is misaligned when either of its two low bits is set.
    function automatic logic is_misaligned(input logic [1:0] pc_lsb);
        return (pc_lsb != 2'b00);
    endfunction

endpackage

// File: rtl/imem_starve_cnt.sv
// -----------------------------------------------------------------------------
// imem_starve_cnt
// Saturating count of consecutive cycles a loader request has waited without
// a grant. force_slot is raised once the count reaches STARVE_MAX so that the
// arbiter hands the loader the next slot even while fetch keeps requesting.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   ld_req     : loader request
//   ld_gnt     : loader grant issued this cycle
//   force_slot : count has reached STARVE_MAX
// -----------------------------------------------------------------------------
module imem_starve_cnt #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ld_req,
    input  logic ld_gnt,
    output logic force_slot
);

    // Extra headroom keeps the width non-zero even for STARVE_MAX = 0.
    localparam int CNT_W = $clog2(STARVE_MAX + 2);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt_r;

    // Wait counter: clears on a grant or when the request drops, saturates at MAX_C.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (ld_gnt || !ld_req) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_r != MAX_C) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign force_slot = (cnt_r == MAX_C);

endmodule

// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter
// Shares the single-port instruction RAM between the fetch stage (reads) and
// the boot/debug loader (writes). The core is held in LOAD until the loader
// signals ld_done; afterwards fetch has priority in RUN. Misaligned fetch PCs
// do not touch the RAM and return a NOP flagged with fetch_misalign.
//
// Optional build macro: IMEM_ARB_STARVE_EN
//   defined   - a loader request waiting STARVE_MAX cycles in RUN is forced a slot
//   undefined - the loader is only served in RUN when fetch_req is low
//
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   fetch_req/fetch_pc         : fetch read request and byte PC
//   fetch_gnt                  : fetch accepted this cycle (combinational)
//   fetch_valid/inst/misalign  : response, one cycle after fetch_gnt
//   ld_req/ld_addr/ld_data     : loader write request, byte address, data
//   ld_gnt                     : write accepted this cycle (combinational)
//   ld_done                    : loader finished, releases the core
//   cpu_run                    : core released (FSM in RUN)
//   mem_en/we/addr/wdata       : RAM port, combinational with the grant
//   mem_rdata                  : RAM read data, one cycle after a read
// -----------------------------------------------------------------------------
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int PC_WIDTH   = DEF_PC_WIDTH,
    parameter int INST_WIDTH = DEF_INST_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_req,
    input  logic [PC_WIDTH-1:0]   fetch_pc,
    output logic                  fetch_gnt,
    output logic                  fetch_valid,
    output logic [INST_WIDTH-1:0] fetch_inst,
    output logic                  fetch_misalign,
    input  logic                  ld_req,
    input  logic [PC_WIDTH-1:0]   ld_addr,
    input  logic [INST_WIDTH-1:0] ld_data,
    output logic                  ld_gnt,
    input  logic                  ld_done,
    output logic                  cpu_run,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [INST_WIDTH-1:0] mem_wdata,
    input  logic [INST_WIDTH-1:0] mem_rdata
);

    localparam logic [INST_WIDTH-1:0] NOP_W = INST_WIDTH'(NOP_INST);

    imem_state_e           state_r;
    imem_state_e           state_next_s;
    logic                  fetch_gnt_s;
    logic                  ld_gnt_s;
    logic                  force_s;
    logic                  misalign_s;
    logic                  valid_r;
    logic                  misalign_r;
    logic [INST_WIDTH-1:0] hold_r;
    logic [INST_WIDTH-1:0] resp_inst_s;
    logic                  unused_addr_bits_s;

`ifdef IMEM_ARB_STARVE_EN
    imem_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk        (clk),
        .rst        (rst),
        .ld_req     (ld_req),
        .ld_gnt     (ld_gnt_s),
        .force_slot (force_s)
    );
`else
    localparam int unused_starve_max = STARVE_MAX;
    assign force_s = 1'b0;
`endif

    // Address bits above the RAM depth wrap; loader byte offset is ignored.
    assign unused_addr_bits_s = ^{fetch_pc[PC_WIDTH-1:ADDR_WIDTH+2],
                                  ld_addr[PC_WIDTH-1:ADDR_WIDTH+2],
                                  ld_addr[1:0]};

    assign misalign_s = is_misaligned(fetch_pc[1:0]);

    // Next-state and grant selection; at most one grant per cycle.
    always_comb begin
        state_next_s = state_r;
        fetch_gnt_s  = 1'b0;
        ld_gnt_s     = 1'b0;
        case (state_r)
            ST_LOAD: begin
                // Fetch is ignored here, not queued.
                ld_gnt_s = ld_req;
                if (ld_done) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (fetch_req && !force_s) begin
                    fetch_gnt_s = 1'b1;
                end else begin
                    ld_gnt_s = ld_req;
                end
            end
            default: begin
                state_next_s = ST_LOAD;
            end
        endcase
    end

    // RAM port drive; a misaligned fetch is granted but leaves the RAM idle.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = fetch_pc[ADDR_WIDTH+1:2];
        mem_wdata = {INST_WIDTH{1'b0}};
        if (ld_gnt_s) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = ld_addr[ADDR_WIDTH+1:2];
            mem_wdata = ld_data;
        end else if (fetch_gnt_s && !misalign_s) begin
            mem_en    = 1'b1;
        end else begin
            mem_en    = 1'b0;
        end
    end

    // FSM state and fetch response tracking; reset drops any in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_LOAD;
            valid_r    <= 1'b0;
            misalign_r <= 1'b0;
            hold_r     <= {INST_WIDTH{1'b0}};
        end else begin
            state_r    <= state_next_s;
            valid_r    <= fetch_gnt_s;
            misalign_r <= fetch_gnt_s & misalign_s;
            if (valid_r) begin
                hold_r <= resp_inst_s;
            end else begin
                hold_r <= hold_r;
            end
        end
    end

    // RAM data arrives the cycle after the read, so the response mux is live
    // while valid and the hold register keeps it stable afterwards.
    assign resp_inst_s    = misalign_r ? NOP_W : mem_rdata;
    assign fetch_inst     = valid_r ? resp_inst_s : hold_r;
    assign fetch_valid    = valid_r;
    assign fetch_misalign = misalign_r;
    assign fetch_gnt      = fetch_gnt_s;
    assign ld_gnt         = ld_gnt_s;
    assign cpu_run        = (state_r == ST_RUN);

endmodule

// File: tb/tb_imem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_arbiter
// Directed table, hand sequences for starvation and reset mid-read, then
// random traffic, all checked against a behavioural model of the arbiter
// rules and a separate expected-memory image.
// -----------------------------------------------------------------------------
module tb_imem_arbiter;

    localparam int          STARVE_MAX = 4;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic        fetch_gnt;
    logic        fetch_valid;
    logic [31:0] fetch_inst;
    logic        fetch_misalign;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_gnt;
    logic        ld_done;
    logic        cpu_run;
    logic        mem_en;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    imem_arbiter #(
        .PC_WIDTH   (32),
        .INST_WIDTH (32),
        .ADDR_WIDTH (9),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_req      (fetch_req),
        .fetch_pc       (fetch_pc),
        .fetch_gnt      (fetch_gnt),
        .fetch_valid    (fetch_valid),
        .fetch_inst     (fetch_inst),
        .fetch_misalign (fetch_misalign),
        .ld_req         (ld_req),
        .ld_addr        (ld_addr),
        .ld_data        (ld_data),
        .ld_gnt         (ld_gnt),
        .ld_done        (ld_done),
        .cpu_run        (cpu_run),
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical RAM macro stand-in.
    logic [31:0] ram [0:511];
    logic [31:0] rdata_r;
    always @(posedge clk) begin
        if (mem_en === 1'b1) begin
            if (mem_we === 1'b1) ram[mem_addr] <= mem_wdata;
            else rdata_r <= ram[mem_addr];
        end
    end
    assign mem_rdata = rdata_r;

    int checks   = 0;
    int failures = 0;
    bit do_chk   = 1'b0;

    // Behavioural model state.
    bit          m_run;
    int          m_cnt;
    bit          m_valid;
    bit          m_mis;
    logic [31:0] m_inst;
    logic [31:0] exp_mem [0:511];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    function automatic int word_of(input logic [31:0] a);
        return int'((a >> 2) % 512);
    endfunction

    // One clock cycle: drive, compare against the model just before the edge,
    // then advance the model by the rules of the arbiter.
    task automatic step(input logic r, input logic fr, input logic [31:0] pc,
                        input logic lr, input logic [31:0] la, input logic [31:0] ld,
                        input logic dn);
        bit e_fg, e_lg, e_en, force_slot, mis;
        int e_addr;
        @(negedge clk);
        rst = r; fetch_req = fr; fetch_pc = pc;
        ld_req = lr; ld_addr = la; ld_data = ld; ld_done = dn;
        #4;
        mis = (pc % 4) != 0;
`ifdef IMEM_ARB_STARVE_EN
        force_slot = m_run && lr && (m_cnt >= STARVE_MAX);
`else
        force_slot = 1'b0;
`endif
        if (!m_run) begin
            e_fg = 1'b0; e_lg = lr;
        end else if (fr && !force_slot) begin
            e_fg = 1'b1; e_lg = 1'b0;
        end else begin
            e_fg = 1'b0; e_lg = lr;
        end
        e_en   = e_lg || (e_fg && !mis);
        e_addr = e_lg ? word_of(la) : word_of(pc);
        if (do_chk) begin
            check("fetch_gnt", 32'(fetch_gnt), 32'(e_fg));
            check("ld_gnt", 32'(ld_gnt), 32'(e_lg));
            check("cpu_run", 32'(cpu_run), 32'(m_run));
            check("mem_en", 32'(mem_en), 32'(e_en));
            check("mem_we", 32'(mem_we), 32'(e_lg));
            if (e_en) check("mem_addr", 32'(mem_addr), 32'(e_addr));
            if (e_lg) check("mem_wdata", mem_wdata, ld);
            check("fetch_valid", 32'(fetch_valid), 32'(m_valid));
            if (m_valid) check("fetch_misalign", 32'(fetch_misalign), 32'(m_mis));
            check("fetch_inst", fetch_inst, m_inst);
        end
        if (e_lg) exp_mem[word_of(la)] = ld;
        if (r) begin
            m_run = 1'b0; m_cnt = 0; m_valid = 1'b0; m_mis = 1'b0; m_inst = 32'h0;
        end else begin
            if (e_fg) begin
                m_mis  = mis;
                m_inst = mis ? NOP : exp_mem[word_of(pc)];
            end
            m_valid = e_fg;
            if (!m_run && dn) m_run = 1'b1;
            if (e_lg || !lr) m_cnt = 0;
            else if (m_cnt < STARVE_MAX) m_cnt++;
        end
    endtask

    typedef struct {
        logic        fr;
        logic [31:0] pc;
        logic        lr;
        logic [31:0] la;
        logic [31:0] ld;
        logic        dn;
        logic        fg, lg, run, en, we;
        logic [8:0]  addr;
        logic        vld, mis;
        logic [31:0] inst;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic [31:0] pc_v;
        logic [31:0] la_v;
        for (int i = 0; i < 512; i++) begin
            ram[i]     = 32'h0;
            exp_mem[i] = 32'h0;
        end
        rdata_r = 32'h0;
        m_run = 1'b0; m_cnt = 0; m_valid = 1'b0; m_mis = 1'b0; m_inst = 32'h0;

        //            fr    pc         lr    la          ld            dn  | fg  lg  run en  we  addr  vld mis inst
        tbl[0]  = '{1'b1, 32'h8,   1'b1, 32'h8,   32'hDEADBEEF, 1'b0, 1'b0,1'b1,1'b0,1'b1,1'b1,9'd2,1'b0,1'b0,32'h0};
        tbl[1]  = '{1'b1, 32'h8,   1'b1, 32'h0,   32'h11111111, 1'b0, 1'b0,1'b1,1'b0,1'b1,1'b1,9'd0,1'b0,1'b0,32'h0};
        tbl[2]  = '{1'b1, 32'h8,   1'b1, 32'h7,   32'h22222222, 1'b1, 1'b0,1'b1,1'b0,1'b1,1'b1,9'd1,1'b0,1'b0,32'h0};
        tbl[3]  = '{1'b1, 32'h8,   1'b0, 32'h0,   32'h0,        1'b0, 1'b1,1'b0,1'b1,1'b1,1'b0,9'd2,1'b0,1'b0,32'h0};
        tbl[4]  = '{1'b1, 32'h6,   1'b0, 32'h0,   32'h0,        1'b0, 1'b1,1'b0,1'b1,1'b0,1'b0,9'd0,1'b1,1'b0,32'hDEADBEEF};
        tbl[5]  = '{1'b1, 32'h800, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1,1'b0,1'b1,1'b1,1'b0,9'd0,1'b1,1'b1,NOP};
        tbl[6]  = '{1'b1, 32'h4,   1'b0, 32'h0,   32'h0,        1'b0, 1'b1,1'b0,1'b1,1'b1,1'b0,9'd1,1'b1,1'b0,32'h11111111};
        tbl[7]  = '{1'b0, 32'h0,   1'b0, 32'h0,   32'h0,        1'b0, 1'b0,1'b0,1'b1,1'b0,1'b0,9'd0,1'b1,1'b0,32'h22222222};
        tbl[8]  = '{1'b0, 32'h0,   1'b0, 32'h0,   32'h0,        1'b0, 1'b0,1'b0,1'b1,1'b0,1'b0,9'd0,1'b0,1'b0,32'h22222222};
        tbl[9]  = '{1'b0, 32'h0,   1'b1, 32'h80C, 32'h33333333, 1'b0, 1'b0,1'b1,1'b1,1'b1,1'b1,9'd3,1'b0,1'b0,32'h22222222};
        tbl[10] = '{1'b1, 32'hC,   1'b0, 32'h0,   32'h0,        1'b0, 1'b1,1'b0,1'b1,1'b1,1'b0,9'd3,1'b0,1'b0,32'h22222222};
        tbl[11] = '{1'b0, 32'h0,   1'b0, 32'h0,   32'h0,        1'b0, 1'b0,1'b0,1'b1,1'b0,1'b0,9'd0,1'b1,1'b0,32'h33333333};

        // Power-on reset; outputs are unknown until the first edge.
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        do_chk = 1'b1;
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("reset_cpu_run", 32'(cpu_run), 32'h0);
        check("reset_fetch_valid", 32'(fetch_valid), 32'h0);
        check("reset_fetch_inst", fetch_inst, 32'h0);

        // Directed table: load, release, aligned/misaligned fetch, wrap.
        for (int i = 0; i < 12; i++) begin
            step(1'b0, tbl[i].fr, tbl[i].pc, tbl[i].lr, tbl[i].la, tbl[i].ld, tbl[i].dn);
            check($sformatf("tbl%0d_fetch_gnt", i), 32'(fetch_gnt), 32'(tbl[i].fg));
            check($sformatf("tbl%0d_ld_gnt", i), 32'(ld_gnt), 32'(tbl[i].lg));
            check($sformatf("tbl%0d_cpu_run", i), 32'(cpu_run), 32'(tbl[i].run));
            check($sformatf("tbl%0d_mem_en", i), 32'(mem_en), 32'(tbl[i].en));
            check($sformatf("tbl%0d_mem_we", i), 32'(mem_we), 32'(tbl[i].we));
            if (tbl[i].en) check($sformatf("tbl%0d_mem_addr", i), 32'(mem_addr), 32'(tbl[i].addr));
            check($sformatf("tbl%0d_fetch_valid", i), 32'(fetch_valid), 32'(tbl[i].vld));
            if (tbl[i].vld) check($sformatf("tbl%0d_fetch_misalign", i), 32'(fetch_misalign), 32'(tbl[i].mis));
            check($sformatf("tbl%0d_fetch_inst", i), fetch_inst, tbl[i].inst);
        end

        // Starvation: fetch and loader both request continuously.
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 32'h10, 1'b1, 32'h10, 32'h44444444, 1'b0);
`ifdef IMEM_ARB_STARVE_EN
            check($sformatf("starve%0d_ld_gnt", i), 32'(ld_gnt), (i == 4) ? 32'h1 : 32'h0);
            check($sformatf("starve%0d_fetch_gnt", i), 32'(fetch_gnt), (i == 4) ? 32'h0 : 32'h1);
`else
            check($sformatf("starve%0d_ld_gnt", i), 32'(ld_gnt), 32'h0);
            check($sformatf("starve%0d_fetch_gnt", i), 32'(fetch_gnt), 32'h1);
`endif
        end
        step(1'b0, 1'b0, 32'h10, 1'b1, 32'h10, 32'h44444444, 1'b0);
        check("starve_release_ld_gnt", 32'(ld_gnt), 32'h1);

        // Reset in the cycle after a fetch grant discards the read.
        step(1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 1'b0);
        check("midrd_fetch_gnt", 32'(fetch_gnt), 32'h1);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("midrd_valid_before", 32'(fetch_valid), 32'h1);
        step(1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 1'b0);
        check("midrd_fetch_valid", 32'(fetch_valid), 32'h0);
        check("midrd_cpu_run", 32'(cpu_run), 32'h0);
        check("midrd_fetch_gnt_load", 32'(fetch_gnt), 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            pc_v = 32'($urandom_range(0, 4095)) | (32'($urandom_range(0, 3)) << 12);
            if ($urandom_range(0, 7) != 0) pc_v = pc_v & 32'hFFFF_FFFC;
            la_v = 32'($urandom_range(0, 4095)) | (32'($urandom_range(0, 3)) << 12);
            step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0, pc_v,
                 ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0, la_v, 32'($urandom),
                 ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
